// File: rtl/mm_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for res = x^e mod m, driving one
// Montgomery multiplier through a req/val handshake.
module mm_modexp_ctrl #(
    parameter int unsigned K     = 4096,
    parameter int unsigned E_W   = 4096,
    parameter int unsigned CNT_W = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K-1:0]   x,
    input  logic [E_W-1:0] e,
    input  logic [K-1:0]   m,
    input  logic [K-1:0]   r_mod,
    input  logic [K-1:0]   r2_mod,
    output logic           busy,
    output logic           done,
    output logic [K-1:0]   res,
    output logic [K-1:0]   mm_x,
    output logic [K-1:0]   mm_y,
    output logic [K-1:0]   mm_m,
    output logic           mm_req,
    input  logic [K-1:0]   mm_res,
    input  logic           mm_val
);

    typedef enum logic [2:0] {
        IDLE, TOMONT, SCAN, SQR, MUL, FROMMONT, FIN
    } state_t;

    state_t         state;
    logic [K-1:0]   xm;
    logic [K-1:0]   acc;
    logic [E_W-1:0] ebuf;
    logic [CNT_W-1:0] idx;
    logic           issued;

    logic           cur_bit;
    logic           idx_zero;
    logic           mm_done;

    assign mm_m = m;

    always_comb begin
        cur_bit = 1'b0;
        for (int unsigned i = 0; i < E_W; i++) begin
            if (idx == CNT_W'(i)) cur_bit = ebuf[i];
        end
        idx_zero = (idx == '0);
        // A completion is only taken once the request pulse has been seen by
        // the multiplier; this also discards val pulses landing on the issue cycle.
        mm_done  = issued && !mm_req && mm_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            res    <= '0;
            mm_x   <= '0;
            mm_y   <= '0;
            mm_req <= 1'b0;
            xm     <= '0;
            acc    <= '0;
            ebuf   <= '0;
            idx    <= '0;
            issued <= 1'b0;
        end else begin
            mm_req <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // xm holds the normal-domain base until TOMONT replaces it.
                        xm     <= x;
                        ebuf   <= e;
                        acc    <= r_mod;
                        idx    <= CNT_W'(E_W - 1);
                        busy   <= 1'b1;
                        issued <= 1'b0;
                        state  <= TOMONT;
                    end
                end
                TOMONT: begin
                    if (!issued) begin
                        mm_x   <= xm;
                        mm_y   <= r2_mod;
                        mm_req <= 1'b1;
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        xm     <= mm_res;
                        issued <= 1'b0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_bit) acc <= xm;
                    if (idx_zero) begin
                        state <= FROMMONT;
                    end else begin
                        idx <= idx - CNT_W'(1);
                        if (cur_bit) state <= SQR;
                    end
                end
                SQR: begin
                    if (!issued) begin
                        mm_x   <= acc;
                        mm_y   <= acc;
                        mm_req <= 1'b1;
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        acc    <= mm_res;
                        issued <= 1'b0;
                        if (cur_bit) begin
                            state <= MUL;
                        end else if (idx_zero) begin
                            state <= FROMMONT;
                        end else begin
                            idx   <= idx - CNT_W'(1);
                            state <= SQR;
                        end
                    end
                end
                MUL: begin
                    if (!issued) begin
                        mm_x   <= acc;
                        mm_y   <= xm;
                        mm_req <= 1'b1;
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        acc    <= mm_res;
                        issued <= 1'b0;
                        if (idx_zero) begin
                            state <= FROMMONT;
                        end else begin
                            idx   <= idx - CNT_W'(1);
                            state <= SQR;
                        end
                    end
                end
                FROMMONT: begin
                    if (!issued) begin
                        mm_x   <= acc;
                        mm_y   <= {{(K-1){1'b0}}, 1'b1};
                        mm_req <= 1'b1;
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        res    <= mm_res;
                        issued <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_modexp_ctrl.sv
// Bench for mm_modexp_ctrl at K=16: behavioural Montgomery multiplier with
// programmable latency, plain modular-exponentiation reference model.
module tb_mm_modexp_ctrl;

    localparam int unsigned K     = 16;
    localparam int unsigned E_W   = 16;
    localparam int unsigned CNT_W = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [K-1:0]   x, m, r_mod, r2_mod, res, mm_x, mm_y, mm_m, mm_res;
    logic [E_W-1:0] e;
    logic           busy, done, mm_req, mm_val;

    int total = 0;
    int bad   = 0;

    int           lat      = 1;
    int           req_cnt  = 0;
    bit           pend     = 1'b0;
    logic [K-1:0] cap_x, cap_y;
    logic [K-1:0] exp_res  = '0;
    bit           exp_busy = 1'b0;
    int           done_cnt = 0;
    bit           prev_done = 1'b0;
    bit           prev_req  = 1'b0;

    mm_modexp_ctrl #(.K(K), .E_W(E_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .e(e), .m(m),
        .r_mod(r_mod), .r2_mod(r2_mod), .busy(busy), .done(done), .res(res),
        .mm_x(mm_x), .mm_y(mm_y), .mm_m(mm_m), .mm_req(mm_req),
        .mm_res(mm_res), .mm_val(mm_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // a*b*2^-16 mod mm by bitwise halving
    function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] mm);
        logic [63:0] t;
        t = 64'(a) * 64'(b);
        for (int i = 0; i < 16; i++) begin
            if (t[0]) t = t + 64'(mm);
            t = t >> 1;
        end
        return 16'(t % 64'(mm));
    endfunction

    function automatic logic [15:0] modpow(input logic [15:0] b, input logic [15:0] ex,
                                           input logic [15:0] mm);
        logic [63:0] r, bb;
        r  = 64'(1) % 64'(mm);
        bb = 64'(b) % 64'(mm);
        for (int i = 15; i >= 0; i--) begin
            r = (r * r) % 64'(mm);
            if (ex[i]) r = (r * bb) % 64'(mm);
        end
        return 16'(r);
    endfunction

    function automatic int op_count(input logic [15:0] ex);
        int bl = 0;
        int pc = 0;
        if (ex == 16'd0) return 2;
        for (int i = 0; i < 16; i++) begin
            if (ex[i]) begin
                bl = i + 1;
                pc++;
            end
        end
        return 2 + (bl - 1) + (pc - 1);
    endfunction

    // Behavioural multiplier
    initial begin
        logic [K-1:0] r;
        mm_val = 1'b0;
        mm_res = '0;
        forever begin
            @(posedge clk); #1;
            if (mm_req) begin
                cap_x = mm_x;
                cap_y = mm_y;
                req_cnt++;
                pend = 1'b1;
                r = mont(mm_x, mm_y, mm_m);
                repeat (lat) begin
                    @(posedge clk); #1;
                end
                mm_res = r;
                mm_val = 1'b1;
                pend   = 1'b0;
                @(posedge clk); #1;
                mm_val = 1'b0;
            end
        end
    end

    // Compare process
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                exp_busy = 1'b0;
            end else begin
                if (start && !exp_busy && !prev_done) exp_busy = 1'b1;
                if (done) begin
                    chk("done_in_op", 64'(exp_busy), 64'd1);
                    chk("busy_at_done", 64'(busy), 64'd0);
                    chk("res", 64'(res), 64'(exp_res));
                    done_cnt++;
                    exp_busy = 1'b0;
                end
                if (exp_busy && pend) begin
                    chk("mm_x_stable", 64'(mm_x), 64'(cap_x));
                    chk("mm_y_stable", 64'(mm_y), 64'(cap_y));
                end
                if (exp_busy) chk("mm_m", 64'(mm_m), 64'(m));
                if (mm_req) chk("req_pulse", 64'(prev_req), 64'd0);
            end
            chk("busy", 64'(busy), 64'(exp_busy));
            prev_done = done;
            prev_req  = mm_req;
        end
    end

    task automatic setup(input logic [15:0] xi, input logic [15:0] ei,
                         input logic [15:0] mi, input int l);
        x        = xi;
        e        = ei;
        m        = mi;
        r_mod    = 16'((64'd1 << 16) % 64'(mi));
        r2_mod   = 16'((64'd1 << 32) % 64'(mi));
        lat      = l;
        exp_res  = modpow(xi, ei, mi);
        req_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
    endtask

    task automatic finish_checks(input logic [15:0] ei);
        repeat (3) @(negedge clk);
        chk("mm_ops", 64'(req_cnt), 64'(op_count(ei)));
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("res_hold", 64'(res), 64'(exp_res));
    endtask

    task automatic run_op(input logic [15:0] xi, input logic [15:0] ei, input logic [15:0] mi,
                          input int l, input bit has_lit, input logic [15:0] lit);
        setup(xi, ei, mi, l);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        finish_checks(ei);
        if (has_lit) chk("res_literal", 64'(res), 64'(lit));
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        setup(16'd0, 16'd0, 16'd7, 1);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(mm_req), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_mm_x", 64'(mm_x), 64'd0);
        chk("rst_mm_y", 64'(mm_y), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'd3, 16'd5,      16'd7,      1,  1'b1, 16'd5);
        run_op(16'd3, 16'd0,      16'd7,      4,  1'b1, 16'd1);
        run_op(16'd0, 16'd9,      16'd11,     20, 1'b1, 16'd0);
        run_op(16'd6, 16'd1,      16'd7,      2,  1'b1, 16'd6);
        run_op(16'd2, 16'hFFFF,   16'hFFF1,   3,  1'b0, 16'd0);

        // Stray val during SCAN and a start while busy must both be ignored
        setup(16'd7, 16'h0010, 16'd13, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(req_cnt == 1 && !pend) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("tomont_seen", 64'(req_cnt), 64'd1);
        repeat (2) @(negedge clk);
        mm_res = 16'hBEEF;
        mm_val = 1'b1;
        @(negedge clk);
        mm_val = 1'b0;
        x      = 16'd5;
        e      = 16'd3;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_done();
        finish_checks(16'h0010);

        // Reset during a squaring wait, stale val afterwards
        setup(16'd5, 16'h00B7, 16'd251, 15);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(req_cnt == 3 && pend) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("sqr_wait_seen", 64'(req_cnt), 64'd3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_res", 64'(res), 64'd0);
        chk("mid_rst_mm_x", 64'(mm_x), 64'd0);
        chk("mid_rst_req", 64'(mm_req), 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_rst", 64'(done_cnt), 64'd0);
        chk("idle_after_stale", 64'(busy), 64'd0);
        run_op(16'd5, 16'h00B7, 16'd251, 5, 1'b0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
